// File: rtl/booth_job_sequencer.sv
// Front end for the Booth multiplier core: queues operand pairs, holds core
// start with stable operands, captures the product and watches for a hung core.
module booth_job_sequencer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_mcand,
  input  logic [WIDTH-1:0]     in_mplier,
  output logic                 core_start,
  output logic [WIDTH-1:0]     core_mcand,
  output logic [WIDTH-1:0]     core_mplier,
  input  logic                 core_done,
  input  logic [2*WIDTH-1:0]   core_product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic [7:0]           last_lat,
  output logic                 err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  TO_CNT   = 8'(TIMEOUT);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  logic signed [WIDTH-1:0] mc_mem_q [DEPTH];
  logic signed [WIDTH-1:0] mp_mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [AW:0]             count_q, count_d;
  logic [1:0]              state_q, state_d;
  logic [7:0]              cnt_q, cnt_d, issue_len;
  logic signed [WIDTH-1:0] mcand_q, mplier_q;
  logic                    out_valid_q, err_q;
  logic [2*WIDTH-1:0]      out_product_q;
  logic [7:0]              last_lat_q;
  logic                    empty, full, push, pop, capture, abort, enter_issue;

  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == FULL_CNT);
    push        = in_valid && !full;
    issue_len   = sat_inc8(cnt_q);
    capture     = (state_q == S_ISSUE) && core_done;
    // A done arriving on the last allowed cycle still counts as a completion.
    abort       = (state_q == S_ISSUE) && !core_done && (issue_len == TO_CNT);
    pop         = capture || abort;
    enter_issue = (state_q == S_IDLE) && !empty && !out_valid_q;

    state_d = state_q;
    case (state_q)
      S_IDLE:    if (enter_issue) state_d = S_ISSUE;
      S_ISSUE:   if (pop) state_d = S_RELEASE;
      S_RELEASE: if (!core_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    cnt_d = cnt_q;
    if (enter_issue) cnt_d = '0;
    else if (state_q == S_ISSUE) cnt_d = issue_len;

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mc_mem_q[wr_ptr_q] <= in_mcand;
      mp_mem_q[wr_ptr_q] <= in_mplier;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_valid_q   <= 1'b0;
      err_q         <= 1'b0;
      last_lat_q    <= '0;
      out_product_q <= '0;
      mcand_q       <= '0;
      mplier_q      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      // Operands are latched once per job so they cannot move during ISSUE.
      if (enter_issue) begin
        mcand_q  <= mc_mem_q[rd_ptr_q];
        mplier_q <= mp_mem_q[rd_ptr_q];
      end
      if (capture) begin
        out_valid_q   <= 1'b1;
        out_product_q <= core_product;
        last_lat_q    <= issue_len;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (abort) err_q <= 1'b1;
    end
  end

  assign in_ready    = !full;
  assign core_start  = (state_q == S_ISSUE);
  assign core_mcand  = mcand_q;
  assign core_mplier = mplier_q;
  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;
  assign last_lat    = last_lat_q;
  assign err         = err_q;

endmodule

// File: tb/tb_booth_job_sequencer.sv
// Directed bench for booth_job_sequencer with a behavioural Booth core of
// programmable latency standing in for the real controller and datapath.
module tb_booth_job_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_mcand, in_mplier;
  logic        core_start;
  logic [7:0]  core_mcand, core_mplier;
  logic        core_done;
  logic [15:0] core_product;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_product;
  logic [7:0]  last_lat;
  logic        err;

  int vec_cnt = 0;
  int err_cnt = 0;
  int lat;
  int cnt_m;
  logic [15:0] got_q[$];
  logic signed [15:0] mc_ext, mp_ext;

  typedef struct {
    logic [7:0]  mc;
    logic [7:0]  mp;
    logic [15:0] prod;
  } vec_t;
  vec_t vecs[5];

  booth_job_sequencer #(.WIDTH(8), .DEPTH(2), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mcand(in_mcand), .in_mplier(in_mplier),
    .core_start(core_start), .core_mcand(core_mcand), .core_mplier(core_mplier),
    .core_done(core_done), .core_product(core_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_product(out_product),
    .last_lat(last_lat), .err(err)
  );

  always #5 clk = ~clk;

  // Core stand-in: done rises after lat cycles of start and holds until start drops.
  assign mc_ext = {{8{core_mcand[7]}}, core_mcand};
  assign mp_ext = {{8{core_mplier[7]}}, core_mplier};
  always @(posedge clk) begin
    if (rst || !core_start) begin
      cnt_m     <= 0;
      core_done <= 1'b0;
      if (rst) core_product <= '0;
    end else if (!core_done) begin
      cnt_m <= cnt_m + 1;
      if (cnt_m + 1 == lat) begin
        core_done    <= 1'b1;
        core_product <= mc_ext * mp_ext;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back(out_product);
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] mc, input logic [7:0] mp);
    int n = 0;
    bit ok = 0;
    in_valid  = 1'b1;
    in_mcand  = mc;
    in_mplier = mp;
    while (!ok && n < 300) begin
      if (in_ready) ok = 1;
      tick();
      n++;
    end
    in_valid = 1'b0;
    if (!ok) check("push_accept", 32'd0, 32'd1);
  endtask

  task automatic wait_result(input string name, input logic [15:0] exp);
    int n = 0;
    while (got_q.size() == 0 && n < 400) begin
      tick();
      n++;
    end
    if (got_q.size() == 0) check({name, "_timeout"}, 32'd0, 32'd1);
    else check(name, 32'(got_q.pop_front()), 32'(exp));
  endtask

  task automatic measure_issue(output int len);
    int n = 0;
    len = 0;
    while (!core_start && n < 200) begin
      tick();
      n++;
    end
    while (core_start && len < 300) begin
      len++;
      tick();
    end
  endtask

  initial begin
    int len;
    int refused;
    bit bad;

    vecs[0] = '{8'h03, 8'hFB, 16'hFFF1};
    vecs[1] = '{8'hFF, 8'hFF, 16'h0001};
    vecs[2] = '{8'h7F, 8'h7F, 16'h3F01};
    vecs[3] = '{8'h80, 8'h7F, 16'hC080};
    vecs[4] = '{8'h00, 8'hF9, 16'h0000};

    rst = 1'b1; in_valid = 1'b0; in_mcand = '0; in_mplier = '0;
    out_ready = 1'b1; lat = 4;
    tick();
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_last_lat", 32'(last_lat), 32'd0);
    check("rst_out_product", 32'(out_product), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single job (3, -5): start latency, release timing and latency report.
    push(8'h03, 8'hFB);
    check("t1_start_after_push", 32'(core_start), 32'd0);
    tick();
    check("t1_start_next", 32'(core_start), 32'd1);
    len = 1;
    while (!core_done && len < 100) begin
      tick();
      len++;
    end
    tick();
    check("t1_start_low_after_done", 32'(core_start), 32'd0);
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_product", 32'(out_product), 32'h0000FFF1);
    check("t1_last_lat_observed", 32'(last_lat), 32'(len));
    check("t1_last_lat", 32'(last_lat), 32'd5);
    repeat (3) tick();
    check("t1_out_valid_cleared", 32'(out_valid), 32'd0);
    check("t1_one_pulse", 32'(got_q.size()), 32'd1);
    wait_result("t1_captured", 16'hFFF1);

    for (int i = 0; i < 5; i++) begin
      push(vecs[i].mc, vecs[i].mp);
      wait_result($sformatf("vec%0d_product", i), vecs[i].prod);
      check($sformatf("vec%0d_last_lat", i), 32'(last_lat), 32'd5);
    end

    // Back-to-back pushes, results in order.
    repeat (4) tick();
    in_valid = 1'b1; in_mcand = 8'h80; in_mplier = 8'h80;
    check("t2_ready_a", 32'(in_ready), 32'd1);
    tick();
    in_mcand = 8'h7F; in_mplier = 8'h00;
    check("t2_ready_b", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    wait_result("t2_first", 16'h4000);
    wait_result("t2_second", 16'h0000);

    // Output stall: FIFO fills, third push refused until a pop.
    repeat (6) tick();
    out_ready = 1'b0;
    push(8'h02, 8'h03);
    push(8'h04, 8'h05);
    check("t3_full", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_mcand = 8'hFE; in_mplier = 8'h03;
    refused = 0;
    while (refused < 100) begin
      if (in_ready) begin
        check("t3_pop_before_accept", 32'(out_valid), 32'd1);
        tick();
        break;
      end
      refused++;
      tick();
    end
    in_valid = 1'b0;
    check("t3_third_refused", 32'(refused > 0), 32'd1);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (!out_valid || out_product !== 16'h0006 || core_start) bad = 1;
      tick();
    end
    check("t3_held_stable", 32'(bad), 32'd0);
    check("t3_still_full", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    wait_result("t3_first", 16'h0006);
    wait_result("t3_second", 16'h0014);
    wait_result("t3_third", 16'hFFFA);

    // Hung core: watchdog drops the job, next job runs normally.
    repeat (6) tick();
    lat = 1000;
    push(8'h05, 8'h05);
    measure_issue(len);
    check("t4_issue_len", 32'(len), 32'd10);
    check("t4_err", 32'(err), 32'd1);
    check("t4_no_result", 32'(out_valid), 32'd0);
    check("t4_last_lat_kept", 32'(last_lat), 32'd5);
    lat = 4;
    push(8'h06, 8'h07);
    wait_result("t4_next_job", 16'h002A);
    check("t4_err_sticky", 32'(err), 32'd1);

    // Reset mid-ISSUE with two jobs queued.
    repeat (6) tick();
    got_q.delete();
    push(8'h01, 8'h01);
    push(8'h02, 8'h02);
    len = 0;
    while (!core_start && len < 50) begin
      tick();
      len++;
    end
    tick();
    rst = 1'b1;
    tick();
    check("t5_core_start", 32'(core_start), 32'd0);
    check("t5_out_valid", 32'(out_valid), 32'd0);
    check("t5_fifo_empty", 32'(in_ready), 32'd1);
    check("t5_err_cleared", 32'(err), 32'd0);
    check("t5_last_lat", 32'(last_lat), 32'd0);
    rst = 1'b0;
    repeat (6) tick();
    check("t5_no_issue", 32'(core_start), 32'd0);
    check("t5_no_result", 32'(got_q.size()), 32'd0);
    push(8'hFD, 8'hFC);
    wait_result("t5_new_job", 16'h000C);

    // done on the same cycle the watchdog expires.
    repeat (6) tick();
    lat = 9;
    push(8'h0A, 8'hF6);
    measure_issue(len);
    check("t6_issue_len", 32'(len), 32'd10);
    wait_result("t6_product", 16'hFF9C);
    check("t6_err", 32'(err), 32'd0);
    check("t6_last_lat", 32'(last_lat), 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
